// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, RISC-V decode
// fields and the controller FSM state encoding.
package alu_issue_ctrl_pkg;

    // ALU operation codes, also consumed by the ALU itself
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_LUI = 4'b0010;
    localparam logic [3:0] ALU_ORI = 4'b0011;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and response channels of the ALU issue controller.
// Both handshakes transfer on a rising edge where valid and ready are both high;
// valid, once raised, is held with its payload stable until that transfer.
interface alu_issue_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Req_Valid_i;
    logic                  Req_Ready_o;
    logic [6:0]            Opcode_i;
    logic [2:0]            Funct3_i;
    logic [6:0]            Funct7_i;
    logic [DATA_WIDTH-1:0] Rs1_Data_i;
    logic [DATA_WIDTH-1:0] Rs2_Data_i;
    logic [DATA_WIDTH-1:0] Imm_i;

    logic [3:0]            ALU_Operation_o;
    logic [DATA_WIDTH-1:0] A_o;
    logic [DATA_WIDTH-1:0] B_o;
    logic [DATA_WIDTH-1:0] ALU_Result_i;
    logic                  Zero_i;

    logic                  Rsp_Valid_o;
    logic                  Rsp_Ready_i;
    logic [DATA_WIDTH-1:0] Rsp_Result_o;
    logic                  Rsp_Zero_o;
    logic                  Rsp_Illegal_o;

    // master: issue stage, ALU and writeback side; slave: the controller
    modport master (
        output Req_Valid_i, Opcode_i, Funct3_i, Funct7_i, Rs1_Data_i, Rs2_Data_i, Imm_i,
        input  Req_Ready_o,
        input  ALU_Operation_o, A_o, B_o,
        output ALU_Result_i, Zero_i,
        input  Rsp_Valid_o, Rsp_Result_o, Rsp_Zero_o, Rsp_Illegal_o,
        output Rsp_Ready_i
    );

    modport slave (
        input  Req_Valid_i, Opcode_i, Funct3_i, Funct7_i, Rs1_Data_i, Rs2_Data_i, Imm_i,
        output Req_Ready_o,
        output ALU_Operation_o, A_o, B_o,
        input  ALU_Result_i, Zero_i,
        output Rsp_Valid_o, Rsp_Result_o, Rsp_Zero_o, Rsp_Illegal_o,
        input  Rsp_Ready_i
    );
endinterface

// File: rtl/alu_op_decoder.sv
// Combinational map from opcode/funct3/funct7 to ALU op and operand selects.
module alu_op_decoder
    import alu_issue_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] op,
    output logic       src_b_is_imm,
    output logic       a_is_zero,
    output logic       illegal
);

    always_comb begin
        op           = ALU_ADD;
        src_b_is_imm = 1'b0;
        a_is_zero    = 1'b0;
        illegal      = 1'b1;
        case (opcode)
            OPC_OP: begin
                if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
                    op      = ALU_ADD;
                    illegal = 1'b0;
                end else if (funct3 == F3_ADD_SUB && funct7 == F7_ALT) begin
                    op      = ALU_SUB;
                    illegal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                src_b_is_imm = 1'b1;
                if (funct3 == F3_ADD_SUB) begin
                    op      = ALU_ADD;
                    illegal = 1'b0;
                end else if (funct3 == F3_OR) begin
                    op      = ALU_ORI;
                    illegal = 1'b0;
                end
            end
            OPC_LUI: begin
                op           = ALU_LUI;
                src_b_is_imm = 1'b1;
                a_is_zero    = 1'b1;
                illegal      = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential ALU initiator: decodes a request, holds registered operands at the
// ALU for SETTLE_CYCLES, captures result/zero and offers them as a response.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic   clk,
    input  logic   reset,
    alu_issue_ctrl_if.slave bus,
    output state_t state_dbg
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  zero_q, zero_d;
    logic                  ill_q, ill_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [3:0] dec_op;
    logic       dec_b_imm;
    logic       dec_a_zero;
    logic       dec_illegal;

    alu_op_decoder u_dec (
        .opcode       (bus.Opcode_i),
        .funct3       (bus.Funct3_i),
        .funct7       (bus.Funct7_i),
        .op           (dec_op),
        .src_b_is_imm (dec_b_imm),
        .a_is_zero    (dec_a_zero),
        .illegal      (dec_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= ALU_ADD;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Req_Valid_i) begin
                    // illegal requests skip the ALU and leave its operands untouched
                    if (dec_illegal) begin
                        res_d   = '0;
                        zero_d  = 1'b0;
                        ill_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        op_d    = dec_op;
                        a_d     = dec_a_zero ? '0 : bus.Rs1_Data_i;
                        b_d     = dec_b_imm ? bus.Imm_i : bus.Rs2_Data_i;
                        cnt_d   = CNT_LOAD;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    res_d   = bus.ALU_Result_i;
                    zero_d  = bus.Zero_i;
                    ill_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.Rsp_Ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.Req_Ready_o     = (state_q == S_IDLE);
    assign bus.Rsp_Valid_o     = (state_q == S_RESP);
    assign bus.ALU_Operation_o = op_q;
    assign bus.A_o             = a_q;
    assign bus.B_o             = b_q;
    assign bus.Rsp_Result_o    = res_q;
    assign bus.Rsp_Zero_o      = zero_q;
    assign bus.Rsp_Illegal_o   = ill_q;
    assign state_dbg           = state_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential initiator for the datapath ALU. It accepts decoded instruction fields and operands over a valid/ready request channel, and maps opcode/funct3/funct7 to the 4-bit ALU operation code. It drives registered operands and the operation to the ALU, holds them for a programmable settle time, then captures the ALU result and zero flag. The captured response is presented on a valid/ready channel to the writeback/branch logic.

Parameters:
DATA_WIDTH, 32, operand/result width
SETTLE_CYCLES, 1, cycles the operands and op are held at the ALU before capture (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
Req_Valid_i  in  1  request valid
Req_Ready_o  out  1  request ready; high only in IDLE
Opcode_i  in  7  instruction opcode
Funct3_i  in  3  instruction funct3
Funct7_i  in  7  instruction funct7
Rs1_Data_i  in  DATA_WIDTH  source register 1 value
Rs2_Data_i  in  DATA_WIDTH  source register 2 value
Imm_i  in  DATA_WIDTH  sign-extended/shifted immediate
ALU_Operation_o  out  4  operation code to ALU (registered)
A_o  out  DATA_WIDTH  ALU operand A (registered)
B_o  out  DATA_WIDTH  ALU operand B (registered)
ALU_Result_i  in  DATA_WIDTH  ALU result (combinational from ALU)
Zero_i  in  1  ALU zero flag
Rsp_Valid_o  out  1  response valid
Rsp_Ready_i  in  1  response ready
Rsp_Result_o  out  DATA_WIDTH  captured result
Rsp_Zero_o  out  1  captured zero flag
Rsp_Illegal_o  out  1  request was not a supported instruction

Behaviour:
- Op encodings: ADD=0000, SUB=0001, LUI=0010, ORI=0011.
- Decode table:
  - opcode 0110011, f3 000, f7 0000000 -> ADD, A=rs1, B=rs2.
  - opcode 0110011, f3 000, f7 0100000 -> SUB, A=rs1, B=rs2.
  - opcode 0010011, f3 000 -> ADD, A=rs1, B=imm.
  - opcode 0010011, f3 110 -> ORI, A=rs1, B=imm.
  - opcode 0110111 -> LUI, A=0, B=imm.
  - Anything else is illegal.
- Reset (async): state=IDLE. ALU_Operation_o=0000, A_o=B_o=0. Rsp_Valid_o=0, Rsp_Result_o=0, Rsp_Zero_o=0, Rsp_Illegal_o=0. Settle counter=0. Any in-flight request is dropped.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Req_Ready_o=1 (decoded from state only, no combinational path from Req_Valid_i).
  - Handshake at a rising edge with Req_Valid_i=1: a legal request loads op/A/B, sets counter=SETTLE_CYCLES-1 and moves to EXEC.
  - An illegal request leaves op/A/B unchanged, loads Rsp_Result_o=0, Rsp_Zero_o=0, Rsp_Illegal_o=1 and moves to RESP.
- EXEC:
  - Req_Ready_o=0. Op/A/B are held stable.
  - Counter>0: decrement.
  - Counter==0: capture ALU_Result_i into Rsp_Result_o and Zero_i into Rsp_Zero_o, set Rsp_Illegal_o=0, move to RESP.
- RESP:
  - Rsp_Valid_o=1. All Rsp_* outputs are stable until the handshake.
  - Rsp_Ready_i=1 at an edge -> IDLE and Rsp_Valid_o=0 next cycle.
- Latency, with accept at edge N:
  - Legal request: Rsp_Valid_o high after edge N+SETTLE_CYCLES+1.
  - Illegal request: Rsp_Valid_o high after edge N+1.
- Throughput: at most one request per SETTLE_CYCLES+2 cycles. A new request is never accepted in the same cycle as a response handshake.
- ALU_Operation_o/A_o/B_o keep their last values in IDLE and RESP; they change only on a legal accept.
- Arithmetic is performed by the ALU (wrap-around modulo 2^DATA_WIDTH). This block does no arithmetic beyond the counter.
- Rsp_Ready_i held high while idle has no effect. Req_Valid_i outside IDLE is ignored; the request is not consumed.
- Reset asserted in any state forces the reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package/header:
  - ALU op localparams (ADD/SUB/LUI/ORI), also used by the ALU.
  - RISC-V opcode constants (OP, OP_IMM, LUI).
  - funct3/funct7 constants.
  - FSM state encoding.
- One sub-module: alu_op_decoder, purely combinational. Inputs: opcode, funct3, funct7. Outputs: op, src_b_is_imm, a_is_zero, illegal.

Test Plan:
- R-type ADD, rs1=5, rs2=7, SETTLE_CYCLES=1 -> ALU_Operation_o=0000, A_o=5, B_o=7; Rsp_Valid_o high 2 cycles after accept; Rsp_Result_o=12, Rsp_Zero_o=0.
- R-type SUB, rs1=rs2=0x1234 -> op=0001, Rsp_Result_o=0, Rsp_Zero_o=1. Repeat with rs1=0, rs2=1 -> 0xFFFFFFFF, Zero 0.
- ORI, rs1=0x0F0, imm=0x00F -> op=0011, result 0x0FF. LUI, imm=0x12345000 -> op=0010, A_o=0, result 0x12345000.
- Opcode 0000011 -> Rsp_Illegal_o=1, Rsp_Result_o=0, Rsp_Valid_o 1 cycle after accept; ALU_Operation_o/A_o/B_o unchanged.
- Rsp_Ready_i low for 5 cycles -> Rsp_Valid_o and Rsp_Result_o stable, Req_Ready_o=0; a back-to-back request held valid is accepted the cycle after the response handshake.
- SETTLE_CYCLES=3, ADD 1+1 -> response after 4 edges. Reset pulsed mid-EXEC -> all outputs zero without a clock edge, Req_Ready_o=1 after release, no response emitted.
